// File: rtl/risc16_mc_ctrl_if.sv
// Memory request/acknowledge bundle between the RiSC-16 control FSM and the
// shared instruction/data memory.
interface risc16_mc_ctrl_if;
  // Handshake: mem_req rises with mem_we/mem_addr_sel and holds them stable
  // until the cycle where mem_ack is high; that cycle completes the access.
  logic mem_req;
  logic mem_we;
  logic mem_addr_sel;
  logic mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr_sel,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr_sel,
    output mem_ack
  );
endinterface

// File: rtl/risc16_mc_ctrl.sv
// Multi-cycle control FSM for the RiSC-16 core: fetch/decode/exec/mem sequencing
// around one shared ALU, with a req/ack memory handshake and optional timeout.
module risc16_mc_ctrl #(
  parameter int MEM_TIMEOUT = 0,
  parameter int TO_W        = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [15:0]           ir,
  input  logic                  eq,
  risc16_mc_ctrl_if.master      mem,
  output logic                  ir_we,
  output logic [1:0]            alu_func,
  output logic                  alu_src1_sel,
  output logic [1:0]            alu_src2_sel,
  output logic                  aluout_we,
  output logic                  rf_we,
  output logic [1:0]            rf_wdata_sel,
  output logic                  pc_we,
  output logic [1:0]            pc_sel,
  output logic                  retire,
  output logic                  halted,
  output logic                  bus_err,
  output logic [2:0]            dbg_state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam bit              TO_EN  = (MEM_TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LIM = TO_W'(MEM_TIMEOUT - 1);

  logic [2:0]      r_state;
  logic [2:0]      w_next;
  logic [TO_W-1:0] r_to_cnt;
  logic            r_halted;
  logic            r_bus_err;
  logic            w_req;
  logic            w_mem_we;
  logic            w_addr_sel;
  logic            w_to_hit;
  logic            w_to_err;
  logic [2:0]      w_op;
  logic            w_simm_zero;
  logic            w_unused_ir;

  assign w_op        = ir[15:13];
  assign w_simm_zero = (ir[6:0] == 7'd0);
  assign w_unused_ir = &{1'b0, ir[12:7]};
  // Count value on entry to the final permitted wait cycle of an access.
  assign w_to_hit    = TO_EN && (r_to_cnt == TO_LIM);

  always_comb begin
    w_next       = r_state;
    w_req        = 1'b0;
    w_mem_we     = 1'b0;
    w_addr_sel   = 1'b0;
    w_to_err     = 1'b0;
    ir_we        = 1'b0;
    alu_func     = 2'b00;
    alu_src1_sel = 1'b0;
    alu_src2_sel = 2'b00;
    aluout_we    = 1'b0;
    rf_we        = 1'b0;
    rf_wdata_sel = 2'b00;
    pc_we        = 1'b0;
    pc_sel       = 2'b00;
    retire       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_FETCH;
      end
      S_FETCH: begin
        w_req = 1'b1;
        if (mem.mem_ack) begin
          ir_we  = 1'b1;
          w_next = S_DECODE;
        end else if (w_to_hit) begin
          w_to_err = 1'b1;
          w_next   = S_HALT;
        end
      end
      S_DECODE: w_next = S_EXEC;
      S_EXEC: begin
        w_next = S_FETCH;
        case (w_op)
          3'b000, 3'b001, 3'b010, 3'b011: begin
            rf_we  = 1'b1;
            pc_we  = 1'b1;
            retire = 1'b1;
            if (w_op == 3'b001) alu_src2_sel = 2'b10;
            if (w_op == 3'b010) alu_func = 2'b01;
            if (w_op == 3'b011) begin
              alu_func     = 2'b10;
              alu_src2_sel = 2'b11;
            end
          end
          3'b100, 3'b101: begin
            alu_src2_sel = 2'b10;
            aluout_we    = 1'b1;
            w_next       = S_MEM;
          end
          3'b110: begin
            alu_src1_sel = 1'b1;
            alu_src2_sel = 2'b01;
            pc_we        = 1'b1;
            pc_sel       = eq ? 2'b01 : 2'b00;
            retire       = 1'b1;
          end
          default: begin
            // jalr with a non-zero immediate is the halt encoding.
            retire = 1'b1;
            if (w_simm_zero) begin
              alu_func     = 2'b11;
              rf_we        = 1'b1;
              rf_wdata_sel = 2'b10;
              pc_we        = 1'b1;
              pc_sel       = 2'b10;
            end else begin
              w_next = S_HALT;
            end
          end
        endcase
      end
      S_MEM: begin
        w_req      = 1'b1;
        w_addr_sel = 1'b1;
        w_mem_we   = (w_op == 3'b100);
        if (mem.mem_ack) begin
          rf_we        = (w_op == 3'b101);
          rf_wdata_sel = (w_op == 3'b101) ? 2'b01 : 2'b00;
          pc_we        = 1'b1;
          retire       = 1'b1;
          w_next       = S_FETCH;
        end else if (w_to_hit) begin
          w_to_err = 1'b1;
          w_next   = S_HALT;
        end
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_to_cnt  <= '0;
      r_halted  <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      r_state   <= w_next;
      // Any completed access or non-request cycle restarts the wait count.
      r_to_cnt  <= (w_req && !mem.mem_ack) ? r_to_cnt + 1'b1 : '0;
      r_halted  <= (w_next == S_HALT);
      r_bus_err <= r_bus_err | w_to_err;
    end
  end

  assign mem.mem_req      = w_req;
  assign mem.mem_we       = w_mem_we;
  assign mem.mem_addr_sel = w_addr_sel;
  assign halted           = r_halted;
  assign bus_err          = r_bus_err;
  assign dbg_state        = r_state;

endmodule

// File: tb/tb_risc16_mc_ctrl.sv
// Bench for risc16_mc_ctrl: random programs through a memory responder, with
// per-event expectations queued from an opcode-level model of the control rules.
module tb_risc16_mc_ctrl;

  localparam int W = 17;
  localparam logic [W-1:0] ALL    = '1;
  localparam logic [W-1:0] NO_ALU = ~17'h0001F;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] ir = 16'h0;
  logic        eq = 1'b0;
  logic        ir_we, alu_src1_sel, aluout_we, rf_we, pc_we, retire, halted, bus_err;
  logic [1:0]  alu_func, alu_src2_sel, rf_wdata_sel, pc_sel;
  logic [2:0]  dbg_state;

  risc16_mc_ctrl_if mif ();

  risc16_mc_ctrl #(.MEM_TIMEOUT(4), .TO_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .ir(ir), .eq(eq), .mem(mif),
    .ir_we(ir_we), .alu_func(alu_func), .alu_src1_sel(alu_src1_sel),
    .alu_src2_sel(alu_src2_sel), .aluout_we(aluout_we), .rf_we(rf_we),
    .rf_wdata_sel(rf_wdata_sel), .pc_we(pc_we), .pc_sel(pc_sel), .retire(retire),
    .halted(halted), .bus_err(bus_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] msk_q[$];
  logic [16:0]  prog_q[$];
  int           ret_cyc[$];

  bit ack_block = 1'b0;
  bit block_data = 1'b0;
  int force_delay = -1;

  // ---------------- memory responder and IR/eq model ----------------
  bit busy = 1'b0;
  int wait_left = 0;
  initial mif.mem_ack = 1'b0;

  always @(negedge clk) begin
    if (!reset_n || !mif.mem_req) begin
      busy = 1'b0;
      mif.mem_ack = 1'b0;
    end else begin
      if (!busy) begin
        busy = 1'b1;
        wait_left = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 3));
      end
      if (ack_block || (block_data && mif.mem_addr_sel) ||
          (!mif.mem_addr_sel && prog_q.size() == 0)) begin
        mif.mem_ack = 1'b0;
      end else if (wait_left == 0) begin
        mif.mem_ack = 1'b1;
        busy = 1'b0;
      end else begin
        wait_left--;
        mif.mem_ack = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (ir_we && prog_q.size() > 0) {ir, eq} <= prog_q.pop_front();
  end

  // ---------------- helpers ----------------
  function automatic logic [W-1:0] mk(input logic irw, input logic alw, input logic rfw,
      input logic [1:0] ws, input logic pcw, input logic [1:0] ps, input logic ret,
      input logic rq, input logic mw, input logic as, input logic [1:0] fn,
      input logic s1, input logic [1:0] s2);
    return {irw, alw, rfw, ws, pcw, ps, ret, rq, mw, as, fn, s1, s2};
  endfunction

  function automatic logic [W-1:0] ev_now();
    return {ir_we, aluout_we, rf_we, rf_wdata_sel, pc_we, pc_sel, retire,
            mif.mem_req, mif.mem_we, mif.mem_addr_sel, alu_func, alu_src1_sel, alu_src2_sel};
  endfunction

  function automatic logic [31:0] outs_now();
    return 32'({ir_we, alu_func, alu_src1_sel, alu_src2_sel, aluout_we, rf_we, rf_wdata_sel,
                pc_we, pc_sel, retire, halted, bus_err, mif.mem_req, mif.mem_we,
                mif.mem_addr_sel});
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic push_ev(input logic [W-1:0] e, input logic [W-1:0] m);
    exp_q.push_back(e);
    msk_q.push_back(m);
  endtask

  // Reference model: control events one instruction produces, from the opcode rules.
  task automatic push_instr(input logic [15:0] ins, input logic e);
    logic [2:0] op;
    op = ins[15:13];
    prog_q.push_back({ins, e});
    push_ev(mk(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00), NO_ALU);
    case (op)
      3'd0: push_ev(mk(1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00), ALL);
      3'd1: push_ev(mk(1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b10), ALL);
      3'd2: push_ev(mk(1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 2'b00), ALL);
      3'd3: push_ev(mk(1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 2'b11), ALL);
      3'd4, 3'd5: begin
        push_ev(mk(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b10), ALL);
        if (op == 3'd5)
          push_ev(mk(1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00), NO_ALU);
        else
          push_ev(mk(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 2'b00),
                  NO_ALU & ~17'h03000);
      end
      3'd6: push_ev(mk(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, e ? 2'b01 : 2'b00, 1'b1, 1'b0, 1'b0, 1'b0,
                       2'b00, 1'b1, 2'b01), ALL);
      default: begin
        if (ins[6:0] == 7'd0)
          push_ev(mk(1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 2'b00),
                  ~17'h00003);
        else
          push_ev(mk(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00),
                  NO_ALU & ~17'h03000);
      end
    endcase
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic       prev_req = 1'b0;
  logic       prev_ack = 1'b0;
  logic [1:0] prev_sel = 2'b00;

  always @(negedge clk) begin
    logic [W-1:0] act, e, m;
    #1;
    if (reset_n && (ir_we || aluout_we || rf_we || pc_we || retire)) begin
      act = ev_now();
      if (retire) ret_cyc.push_back(cyc);
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: got %0h expected none (t=%0t)", act, $time);
      end else begin
        e = exp_q.pop_front();
        m = msk_q.pop_front();
        if ((act & m) !== (e & m)) begin
          n_fail++;
          $display("FAIL event: got %0h expected %0h mask %0h (t=%0t)", act, e, m, $time);
        end
      end
    end
    if (reset_n && mif.mem_req && prev_req && !prev_ack) begin
      n_checks++;
      if ({mif.mem_we, mif.mem_addr_sel} !== prev_sel) begin
        n_fail++;
        $display("FAIL req_stable: got %0b expected %0b (t=%0t)",
                 {mif.mem_we, mif.mem_addr_sel}, prev_sel, $time);
      end
    end
    prev_req = reset_n && mif.mem_req;
    prev_ack = mif.mem_ack;
    prev_sel = {mif.mem_we, mif.mem_addr_sel};
  end

  // ---------------- driver tasks ----------------
  task automatic clear_all();
    prog_q.delete();
    exp_q.delete();
    msk_q.delete();
    ret_cyc.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #2;
    clear_all();
    chk("reset_outs_low", outs_now(), 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #2;
    chk("idle_outs", outs_now(), 32'h0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_prog(input string tag, input int bound);
    bit ok;
    ok = 1'b0;
    pulse_start();
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      #2;
      if (halted) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_halted"}, 32'(ok), 32'd1);
    chk({tag, "_no_bus_err"}, 32'(bus_err), 32'd0);
    chk({tag, "_exp_drained"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_prog_drained"}, 32'(prog_q.size()), 32'd0);
  endtask

  function automatic logic [15:0] halt_ins();
    return {3'b111, 6'($urandom), 7'($urandom_range(1, 127))};
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    bit ok;
    logic [15:0] ins;

    // Zero-wait memory: three cycles per instruction.
    do_reset();
    force_delay = 0;
    push_instr(16'h0503, 1'b0);
    push_instr(16'h2503, 1'b0);
    push_instr(halt_ins(), 1'b0);
    run_prog("zero_wait", 40);
    chk("zw_retires", 32'(ret_cyc.size()), 32'd3);
    if (ret_cyc.size() == 3) begin
      chk("zw_gap0", 32'(ret_cyc[1] - ret_cyc[0]), 32'd3);
      chk("zw_gap1", 32'(ret_cyc[2] - ret_cyc[1]), 32'd3);
    end
    // Start pulses in HALT are ignored.
    pulse_start();
    repeat (4) @(negedge clk);
    #2;
    chk("halt_sticky", 32'(halted), 32'd1);
    chk("halt_no_req", 32'(mif.mem_req), 32'd0);

    // Ack on the last permitted cycle completes normally.
    do_reset();
    force_delay = 3;
    push_instr(16'hA8FE, 1'b0);
    push_instr(16'h8280, 1'b0);
    push_instr(halt_ins(), 1'b0);
    run_prog("ack_at_limit", 80);
    force_delay = -1;

    // Randomized programs with random ack latency and eq.
    for (int b = 0; b < 8; b++) begin
      do_reset();
      for (int k = 0; k < int'($urandom_range(4, 10)); k++) begin
        ins = 16'($urandom);
        if (ins[15:13] == 3'b111) ins[6:0] = 7'd0;
        push_instr(ins, 1'($urandom));
      end
      push_instr(halt_ins(), 1'b0);
      run_prog("random", 400);
    end

    // Fetch timeout: four unanswered request cycles end in a bus error.
    do_reset();
    ack_block = 1'b1;
    prog_q.push_back({16'h0503, 1'b0});
    pulse_start();
    repeat (3) @(negedge clk);
    #2;
    chk("to_still_req", 32'(mif.mem_req), 32'd1);
    chk("to_not_halted", 32'(halted), 32'd0);
    @(negedge clk);
    #2;
    chk("to_halted", 32'(halted), 32'd1);
    chk("to_bus_err", 32'(bus_err), 32'd1);
    chk("to_req_drop", 32'(mif.mem_req), 32'd0);
    ack_block = 1'b0;
    pulse_start();
    repeat (3) @(negedge clk);
    #2;
    chk("to_bus_err_sticky", 32'(bus_err), 32'd1);

    // Reset in the middle of a store access.
    do_reset();
    block_data = 1'b1;
    prog_q.push_back({16'h8A81, 1'b0});
    push_ev(mk(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00), NO_ALU);
    push_ev(mk(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b10), ALL);
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #2;
      if (mif.mem_req && mif.mem_addr_sel) begin
        ok = 1'b1;
        break;
      end
    end
    chk("sw_reach_mem", 32'(ok), 32'd1);
    chk("sw_mem_we", 32'(mif.mem_we), 32'd1);
    @(negedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_outs", outs_now(), 32'h0);
    chk("rst_mid_exp_drained", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    block_data = 1'b0;
    clear_all();
    push_instr(16'h0503, 1'b0);
    push_instr(halt_ins(), 1'b0);
    run_prog("restart", 60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/risc16_mc_ctrl.md
Name: risc16_mc_ctrl

Overview:
Multi-cycle control FSM for the RiSC-16 core. It sequences fetch, decode, execute and memory phases around the single shared 16-bit ALU (func codes 00 add, 01 nand, 10 lui, 11 pass src1; eq flag). It drives the ALU function and operand muxes, the register-file, PC and IR write enables, and a req/ack memory handshake. It sits between the datapath (IR, register file, PC, ALU, ALU-out register) and a single-port instruction/data memory.

Parameters:
MEM_TIMEOUT, 0, max cycles mem_req may wait for mem_ack; 0 disables the timeout.
TO_W, 8, width of the timeout counter; MEM_TIMEOUT must be < 2**TO_W.

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse, leaves IDLE
ir  input  16  current IR contents: [15:13] opcode, [12:10] regA, [9:7] regB, [2:0] regC, [6:0] simm7, [9:0] imm10
eq  input  1  ALU equality flag (src1==src2)
mem_ack  input  1  memory completes the current access this cycle
ir_we  output  1  load IR from memory read data
alu_func  output  2  ALU function code
alu_src1_sel  output  1  0=regB, 1=regA
alu_src2_sel  output  2  00=regC, 01=regB, 10=sign-extended simm7, 11={imm10,6'b0}
aluout_we  output  1  latch ALU result into the address register
rf_we  output  1  register write to regA (RF ignores writes to r0)
rf_wdata_sel  output  2  00=ALU, 01=mem read data, 10=PC+1
pc_we  output  1  PC update
pc_sel  output  2  00=PC+1, 01=PC+1+simm7, 10=ALU
mem_req  output  1  memory access request
mem_we  output  1  store (valid with mem_req)
mem_addr_sel  output  1  0=PC, 1=address register
retire  output  1  one-cycle pulse when an instruction completes
halted  output  1  core stopped (halt instruction or bus error)
bus_err  output  1  sticky flag, set by a memory timeout

Behaviour:
- State register only. All control outputs are combinational from the state, ir, eq and mem_ack (Mealy). halted and bus_err are registered.
- Reset (async, reset_n=0): state=IDLE, timeout counter=0, halted=0, bus_err=0. In IDLE every output is 0.
- IDLE: on start=1 go to FETCH. start is ignored in every other state.
- FETCH: mem_req=1, mem_addr_sel=0, mem_we=0. Hold until mem_ack. In the mem_ack cycle ir_we=1, then go to DECODE. mem_ack in the same cycle as the first request is legal (zero-wait memory).
- DECODE: one cycle, all outputs 0, then go to EXEC. The RF reads and the operands settle in this cycle.
- EXEC (one cycle), per opcode:
  - add 000: func 00, src1 regB, src2 regC, rf_we, wdata ALU, pc_we with PC+1, retire. Next FETCH.
  - addi 001: as add, but src2 simm7.
  - nand 010: as add, but func 01.
  - lui 011: func 10, src2 imm. Otherwise as add.
  - sw 100 / lw 101: func 00, src1 regB, src2 simm7, aluout_we. Next MEM.
  - beq 110: func 00, src1 regA, src2 regB, pc_we. pc_sel=01 if eq else 00. retire. Next FETCH.
  - jalr 111 with simm7==0: func 11, src1 regB, rf_we, wdata PC+1, pc_we, pc_sel 10, retire. Next FETCH. RF write and PC write happen on the same edge; the datapath uses the old PC for PC+1.
  - jalr 111 with simm7!=0: halt. No writes, retire=1. Next HALT.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=(opcode==sw). Hold until mem_ack. In the mem_ack cycle:
  - lw: rf_we=1, wdata mem.
  - sw: no RF write.
  - Both: pc_we with PC+1, retire. Next FETCH.
- HALT: halted=1, all other outputs 0. Only reset exits this state.
- Timeout, when MEM_TIMEOUT!=0:
  - The counter clears on entry to FETCH/MEM and increments each cycle mem_req=1 and mem_ack=0.
  - When the count reaches MEM_TIMEOUT without an ack: go to HALT, set bus_err=1 and halted=1. No ir_we, rf_we or pc_we is issued.
  - mem_ack in the same cycle as the limit wins; the access completes normally.
- mem_ack outside FETCH/MEM is ignored.
- mem_req stays high and mem_addr_sel/mem_we stay stable from the first request cycle through the ack cycle.
- retire: exactly one pulse per instruction, including halt. No pulse on a bus error.
- Reset mid-access: the FSM returns to IDLE immediately and mem_req drops asynchronously. No partial write enables are issued.

Test Plan:
- Reset, then start, then add r1,r2,r3 with zero-wait memory -> cycles FETCH(ack)/DECODE/EXEC; in EXEC func=00, src2_sel=00, rf_we=1, pc_we=1, pc_sel=00, retire=1; 3 cycles per instruction.
- beq r1,r2,+5 with eq=1, then eq=0 -> pc_sel=01 and pc_sel=00 respectively; rf_we=0 in both; one retire each.
- lw r4,r5,-2 with mem_ack delayed 2 cycles -> aluout_we in EXEC; mem_req=1, addr_sel=1, mem_we=0 for 3 cycles; rf_we=1, wdata_sel=01, pc_we in the ack cycle only.
- jalr r7,r3 then jalr r0,r0,1 -> first: pc_sel=10, rf_we=1, wdata_sel=10; second: halted=1 next cycle, no writes, start pulses ignored.
- MEM_TIMEOUT=4 with mem_ack held low during FETCH -> after 4 request cycles bus_err=1, halted=1, ir_we never asserted; ack exactly on the 4th cycle instead -> normal fetch.
- reset_n pulsed low during MEM of sw -> mem_req and mem_we drop immediately, state IDLE, bus_err=0, no pc_we; start restarts with FETCH.
